// File: rtl/collision_detect.sv
// Per-frame player/obstacle overlap scanner: fetches each obstacle slot over a
// request/acknowledge port, latches game_over on the first hit and scores clean frames.
module collision_detect #(
  parameter int NUM_OBS     = 4,
  parameter int XW          = 10,
  parameter int YW          = 10,
  parameter int SCOREW      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk3,
  input  logic              reset,
  input  logic              start,
  input  logic              tick,
  input  logic [XW-1:0]     px,
  input  logic [YW-1:0]     py,
  input  logic [XW-1:0]     pw,
  input  logic [YW-1:0]     ph,
  output logic              obs_req,
  output logic [3:0]        obs_idx,
  input  logic              obs_ack,
  input  logic              obs_active,
  input  logic [XW-1:0]     ox,
  input  logic [YW-1:0]     oy,
  input  logic [XW-1:0]     ow,
  input  logic [YW-1:0]     oh,
  output logic              pause,
  output logic              game_over,
  output logic              frame_done,
  output logic [SCOREW-1:0] score,
  output logic              overrun,
  output logic              fetch_err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_OBS - 1);

  function automatic logic [SCOREW-1:0] sat_inc(input logic [SCOREW-1:0] v);
    return (&v) ? v : v + SCOREW'(1);
  endfunction

  // End coordinates carry one extra bit so x+w never wraps; empty rectangles never hit.
  function automatic logic rect_overlap(
    input logic [XW-1:0] ax, aw, bx, bw,
    input logic [YW-1:0] ay, ah, by, bh
  );
    logic [XW:0] a_xe, b_xe;
    logic [YW:0] a_ye, b_ye;
    a_xe = {1'b0, ax} + {1'b0, aw};
    b_xe = {1'b0, bx} + {1'b0, bw};
    a_ye = {1'b0, ay} + {1'b0, ah};
    b_ye = {1'b0, by} + {1'b0, bh};
    return (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0) &&
           ({1'b0, ax} < b_xe) && ({1'b0, bx} < a_xe) &&
           ({1'b0, ay} < b_ye) && ({1'b0, by} < a_ye);
  endfunction

  logic [2:0]        state_q, state_d;
  logic              req_q, req_d;
  logic [3:0]        idx_q, idx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              hit_q, hit_d;
  logic              go_q, go_d;
  logic              done_q, done_d;
  logic [SCOREW-1:0] score_q, score_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;
  logic              start_q;

  logic              pl_ld, ob_ld, act_in;
  logic [XW-1:0]     spx_q, spw_q, sox_q, sow_q;
  logic [YW-1:0]     spy_q, sph_q, soy_q, soh_q;
  logic              act_q;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    idx_d   = idx_q;
    tmo_d   = '0;
    hit_d   = hit_q;
    go_d    = go_q;
    done_d  = 1'b0;
    score_d = score_q;
    ovr_d   = ovr_q | (tick && (state_q != S_IDLE) && (state_q != S_OVER));
    ferr_d  = ferr_q;
    pl_ld   = 1'b0;
    ob_ld   = 1'b0;
    act_in  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) score_d = '0;
        if (tick && start && !go_q) begin
          pl_ld   = 1'b1;
          idx_d   = '0;
          hit_d   = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (obs_ack) begin
          ob_ld   = 1'b1;
          act_in  = obs_active;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          // Abandoned slot is scanned as inactive.
          ob_ld   = 1'b1;
          ferr_d  = 1'b1;
          state_d = S_CHECK;
        end else begin
          tmo_d = tmo_q + TW'(1);
          req_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          hit_d = hit_q | (act_q && rect_overlap(spx_q, spw_q, sox_q, sow_q,
                                                 spy_q, sph_q, soy_q, soh_q));
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            req_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (hit_q) begin
          go_d    = 1'b1;
          state_d = S_OVER;
        end else begin
          score_d = sat_inc(score_q);
          state_d = S_IDLE;
        end
      end
      S_OVER: begin
        if (!start) begin
          go_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk3) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      idx_q   <= '0;
      tmo_q   <= '0;
      hit_q   <= 1'b0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      score_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      hit_q   <= hit_d;
      go_q    <= go_d;
      done_q  <= done_d;
      score_q <= score_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      start_q <= start;
    end
  end

  // Player shadow and fetched obstacle are pure data: no reset needed.
  always_ff @(posedge clk3) begin
    if (pl_ld) begin
      spx_q <= px;
      spy_q <= py;
      spw_q <= pw;
      sph_q <= ph;
    end
    if (ob_ld) begin
      act_q <= act_in;
      sox_q <= ox;
      soy_q <= oy;
      sow_q <= ow;
      soh_q <= oh;
    end
  end

  assign obs_req    = req_q;
  assign obs_idx    = idx_q;
  assign game_over  = go_q;
  assign pause      = go_q;
  assign frame_done = done_q;
  assign score      = score_q;
  assign overrun    = ovr_q;
  assign fetch_err  = ferr_q;
endmodule
